// File: rtl/yapp_chan_pkg.sv
// Shared types for the YAPP channel receiver: FSM states, header layout, FIFO entry layout.
// No logic and no timing of its own.
package yapp_chan_pkg;

    localparam int MAX_LEN = 63;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        PARITY  = 2'd2,
        ABORT   = 2'd3
    } state_e;

    typedef struct packed {
        logic [5:0] len;
        logic [1:0] addr;
    } hdr_t;

    typedef struct packed {
        logic       eop;
        logic [7:0] dat;
    } entry_t;

    localparam entry_t RESYNC_ENTRY = '{eop: 1'b1, dat: 8'h00};

endpackage

// File: rtl/yapp_chan_rx_if.sv
// Router-facing byte channel, FIFO read port and packet status of one YAPP receive channel.
// slave = receiver view, master = router/reader view.
interface yapp_chan_rx_if;

    logic [7:0]  data;
    logic        data_vld;
    logic        suspend;
    logic        rd_en;
    logic [8:0]  rd_data;
    logic        rd_empty;
    logic        pkt_done;
    logic [5:0]  pkt_len;
    logic        pkt_par_err;
    logic        pkt_addr_err;
    logic        pkt_abort;
    logic [15:0] pkt_count;
    logic [15:0] err_count;
    logic        overflow;

    modport slave (
        input  data, data_vld, rd_en,
        output suspend, rd_data, rd_empty, pkt_done, pkt_len, pkt_par_err,
               pkt_addr_err, pkt_abort, pkt_count, err_count, overflow
    );

    modport master (
        output data, data_vld, rd_en,
        input  suspend, rd_data, rd_empty, pkt_done, pkt_len, pkt_par_err,
               pkt_addr_err, pkt_abort, pkt_count, err_count, overflow
    );

endinterface

// File: rtl/yapp_sync_fifo.sv
// Show-ahead synchronous FIFO; written data readable the next cycle.
// Writes while full and reads while empty are dropped; the caller throttles via count_o.
module yapp_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_dat_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_dat_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_fire, rd_fire;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == (AW+1)'(DEPTH));
    assign count_o  = count_q;
    assign rd_dat_o = mem_q[rd_ptr_q];
    assign wr_fire  = wr_en_i && !full_o;
    assign rd_fire  = rd_en_i && !empty_o;

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    // Pointers are power-of-2 wide, so wrap mod DEPTH falls out of the arithmetic.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_fire) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_fire && !rd_fire)      count_q <= count_q + (AW+1)'(1);
            else if (rd_fire && !wr_fire) count_q <= count_q - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/yapp_chan_rx.sv
// YAPP channel receiver: parses header/payload/parity, buffers bytes with eop marks, counts packets.
// Byte accepted same cycle it is seen; suspend is registered and asserts at <= SUSP_MARGIN free entries.
module yapp_chan_rx
    import yapp_chan_pkg::*;
#(
    parameter int         DEPTH       = 64,
    parameter logic [1:0] CHAN_ADDR   = 2'd0,
    parameter int         SUSP_MARGIN = 4,
    parameter int         TIMEOUT     = 255
) (
    input  logic           clock,
    input  logic           reset,
    yapp_chan_rx_if.slave  chan
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e      state_q;
    hdr_t        hdr_q;
    logic [5:0]  rem_q;
    logic [7:0]  par_q;
    logic [TW-1:0] idle_q;
    logic        suspend_q, overflow_q, pkt_done_q;
    logic [5:0]  pkt_len_q;
    logic        pkt_par_err_q, pkt_addr_err_q, pkt_abort_q;
    logic [15:0] pkt_count_q, err_count_q;

    logic          accept, fifo_full, fifo_empty, wr_en, wr_fire, rd_fire;
    logic [8:0]    wr_dat;
    logic [CW-1:0] fifo_cnt, cnt_d;
    logic          in_pkt, idle_cyc, timeout_hit, ovf_accept, to_abort, suspend_d;
    logic          fin_vld, fin_par, fin_abort, fin_addr;

    assign accept      = chan.data_vld && !suspend_q;
    assign in_pkt      = (state_q == PAYLOAD) || (state_q == PARITY);
    assign idle_cyc    = in_pkt && !chan.data_vld && !suspend_q;
    assign timeout_hit = idle_cyc && (idle_q == TW'(TIMEOUT - 1));
    assign ovf_accept  = accept && fifo_full && (state_q != ABORT);
    assign to_abort    = ovf_accept || timeout_hit || ((state_q == ABORT) && fifo_full);
    assign fin_addr    = (hdr_q.addr != CHAN_ADDR);

    always_comb begin
        wr_en     = 1'b0;
        wr_dat    = {1'b0, chan.data};
        fin_vld   = 1'b0;
        fin_par   = 1'b0;
        fin_abort = 1'b0;
        if (state_q == ABORT) begin
            wr_en     = !fifo_full;
            wr_dat    = RESYNC_ENTRY;
            fin_vld   = !fifo_full;
            fin_abort = 1'b1;
        end else if (accept) begin
            wr_en  = 1'b1;
            wr_dat = {state_q == PARITY, chan.data};
            if (state_q == PARITY && !fifo_full) begin
                fin_vld = 1'b1;
                fin_par = (chan.data != par_q);
            end
        end
    end

    assign wr_fire = wr_en && !fifo_full;
    assign rd_fire = chan.rd_en && !fifo_empty;

    always_comb begin
        cnt_d = fifo_cnt;
        if (wr_fire && !rd_fire)      cnt_d = fifo_cnt + CW'(1);
        else if (rd_fire && !wr_fire) cnt_d = fifo_cnt - CW'(1);
    end

    // Suspend also covers the ABORT cycle so the resync entry never competes with a router byte.
    assign suspend_d = ((DEPTH - int'(cnt_d)) <= SUSP_MARGIN) || to_abort;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            hdr_q          <= '0;
            rem_q          <= '0;
            par_q          <= '0;
            idle_q         <= '0;
            suspend_q      <= 1'b0;
            overflow_q     <= 1'b0;
            pkt_done_q     <= 1'b0;
            pkt_len_q      <= '0;
            pkt_par_err_q  <= 1'b0;
            pkt_addr_err_q <= 1'b0;
            pkt_abort_q    <= 1'b0;
            pkt_count_q    <= '0;
            err_count_q    <= '0;
        end else begin
            suspend_q  <= suspend_d;
            pkt_done_q <= fin_vld;
            if (ovf_accept) overflow_q <= 1'b1;

            if (!in_pkt || accept || suspend_q || timeout_hit) idle_q <= '0;
            else if (idle_cyc)                                 idle_q <= idle_q + TW'(1);

            if (fin_vld) begin
                pkt_len_q      <= hdr_q.len;
                pkt_par_err_q  <= fin_par;
                pkt_addr_err_q <= fin_addr;
                pkt_abort_q    <= fin_abort;
                pkt_count_q    <= pkt_count_q + 16'd1;
                if (fin_par || fin_addr || fin_abort) err_count_q <= err_count_q + 16'd1;
            end

            case (state_q)
                IDLE: if (accept) begin
                    hdr_q <= hdr_t'(chan.data);
                    par_q <= chan.data;
                    rem_q <= chan.data[7:2];
                    if (ovf_accept)               state_q <= ABORT;
                    else if (chan.data[7:2] == 0) state_q <= PARITY;
                    else                          state_q <= PAYLOAD;
                end
                PAYLOAD: begin
                    if (ovf_accept || timeout_hit) state_q <= ABORT;
                    else if (accept) begin
                        par_q <= par_q ^ chan.data;
                        rem_q <= rem_q - 6'd1;
                        if (rem_q == 6'd1) state_q <= PARITY;
                    end
                end
                PARITY: begin
                    if (ovf_accept || timeout_hit) state_q <= ABORT;
                    else if (accept)               state_q <= IDLE;
                end
                ABORT: if (!fifo_full) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    yapp_sync_fifo #(.WIDTH(9), .DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .wr_en_i  (wr_en),
        .wr_dat_i (wr_dat),
        .rd_en_i  (chan.rd_en),
        .rd_dat_o (chan.rd_data),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full),
        .count_o  (fifo_cnt)
    );

    assign chan.rd_empty     = fifo_empty;
    assign chan.suspend      = suspend_q;
    assign chan.pkt_done     = pkt_done_q;
    assign chan.pkt_len      = pkt_len_q;
    assign chan.pkt_par_err  = pkt_par_err_q;
    assign chan.pkt_addr_err = pkt_addr_err_q;
    assign chan.pkt_abort    = pkt_abort_q;
    assign chan.pkt_count    = pkt_count_q;
    assign chan.err_count    = err_count_q;
    assign chan.overflow     = overflow_q;

endmodule

// File: tb/tb_yapp_chan_rx.sv
// Scoreboard bench for yapp_chan_rx: FIFO entries and packet status are queued at drive time
// and compared as the reader pops entries and pkt_done pulses.
module tb_yapp_chan_rx;

    localparam int         DEPTH   = 8;
    localparam int         TIMEOUT = 32;
    localparam logic [1:0] CHAN    = 2'd0;

    typedef struct packed {
        logic [5:0] len;
        logic       par;
        logic       addr;
        logic       abort;
    } stat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    yapp_chan_rx_if bus();

    yapp_chan_rx #(.DEPTH(DEPTH), .CHAN_ADDR(CHAN), .SUSP_MARGIN(4), .TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .chan  (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [8:0]  exp_q[$];
    stat_t       stat_q[$];
    bit          rd_enable = 1'b0;
    logic [15:0] m_pkts = 16'd0;
    logic [15:0] m_errs = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reader: pops whenever enabled and data is shown, comparing against the queued entries.
    initial begin
        bus.rd_en = 1'b0;
        forever begin
            @(negedge clock);
            if (rd_enable && !reset && !bus.rd_empty) begin
                if (exp_q.size() == 0) chk("rd_extra", 32'(exp_q.size()), 32'd1);
                else                   chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
                bus.rd_en = 1'b1;
            end else begin
                bus.rd_en = 1'b0;
            end
        end
    end

    initial begin
        stat_t s;
        forever begin
            @(negedge clock);
            if (!reset && bus.pkt_done) begin
                if (stat_q.size() == 0) begin
                    chk("done_extra", 32'(stat_q.size()), 32'd1);
                end else begin
                    s = stat_q.pop_front();
                    m_pkts++;
                    if (s.par || s.addr || s.abort) m_errs++;
                    chk("pkt_len",      32'(bus.pkt_len),      32'(s.len));
                    chk("pkt_par_err",  32'(bus.pkt_par_err),  32'(s.par));
                    chk("pkt_addr_err", 32'(bus.pkt_addr_err), 32'(s.addr));
                    chk("pkt_abort",    32'(bus.pkt_abort),    32'(s.abort));
                    chk("pkt_count",    32'(bus.pkt_count),    32'(m_pkts));
                    chk("err_count",    32'(bus.err_count),    32'(m_errs));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input logic eop);
        int waited = 0;
        bus.data     = b;
        bus.data_vld = 1'b1;
        while (bus.suspend && waited < 3000) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 3000) begin
            chk("suspend_stuck", 32'(waited), 32'd0);
            bus.data_vld = 1'b0;
            return;
        end
        exp_q.push_back({eop, b});
        @(negedge clock);
        bus.data_vld = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] base, input logic [7:0] step,
                            input bit bad_par, input int stop_after);
        logic [7:0] par;
        logic [7:0] b;
        stat_t      s;
        int         len;
        len = int'(hdr[7:2]);
        par = hdr;
        if (stop_after < 0) begin
            s.len   = hdr[7:2];
            s.par   = bad_par;
            s.addr  = (hdr[1:0] != CHAN);
            s.abort = 1'b0;
            stat_q.push_back(s);
        end
        send_byte(hdr, 1'b0);
        for (int i = 0; i < len; i++) begin
            if (stop_after >= 0 && i == stop_after) return;
            b   = base + 8'(i) * step;
            par = par ^ b;
            send_byte(b, 1'b0);
        end
        send_byte(bad_par ? ~par : par, 1'b1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || stat_q.size() != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(exp_q.size() + stat_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        stat_t s;
        bus.data     = 8'h00;
        bus.data_vld = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_rd_empty",  32'(bus.rd_empty),  32'd1);
        chk("rst_suspend",   32'(bus.suspend),   32'd0);
        chk("rst_pkt_done",  32'(bus.pkt_done),  32'd0);
        chk("rst_pkt_count", 32'(bus.pkt_count), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        chk("rst_overflow",  32'(bus.overflow),  32'd0);
        reset     = 1'b0;
        rd_enable = 1'b1;

        send_pkt(8'h0C, 8'd11, 8'd11, 1'b0, -1);
        drain("drain_clean");
        send_pkt(8'h0C, 8'd11, 8'd11, 1'b1, -1);
        drain("drain_par_err");
        send_pkt(8'h05, 8'h5A, 8'h01, 1'b0, -1);
        drain("drain_addr_err");

        // zero-length packet followed immediately by another header
        send_pkt(8'h00, 8'h00, 8'h00, 1'b0, -1);
        send_pkt(8'h12, 8'hA0, 8'h07, 1'b0, -1);
        drain("drain_b2b");

        rd_enable = 1'b0;
        fork
            send_pkt(8'hFC, 8'h01, 8'h03, 1'b0, -1);
            begin
                repeat (30) @(negedge clock);
                chk("full_suspend",  32'(bus.suspend),  32'd1);
                chk("full_rd_empty", 32'(bus.rd_empty), 32'd0);
                chk("full_overflow", 32'(bus.overflow), 32'd0);
                rd_enable = 1'b1;
            end
        join
        drain("drain_long");
        chk("long_overflow", 32'(bus.overflow), 32'd0);
        chk("long_suspend",  32'(bus.suspend),  32'd0);

        send_pkt(8'h28, 8'h40, 8'h01, 1'b0, 2);
        repeat (TIMEOUT - 1) @(negedge clock);
        chk("no_early_abort", 32'(bus.pkt_count), 32'(m_pkts));
        exp_q.push_back(9'h100);
        s.len = 6'd10; s.par = 1'b0; s.addr = 1'b0; s.abort = 1'b1;
        stat_q.push_back(s);
        drain("drain_abort");
        send_pkt(8'h08, 8'hC3, 8'h11, 1'b0, -1);
        drain("drain_after_abort");

        rd_enable = 1'b0;
        send_pkt(8'h14, 8'h20, 8'h02, 1'b0, 2);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_rd_empty",  32'(bus.rd_empty),  32'd1);
        chk("mid_rst_pkt_count", 32'(bus.pkt_count), 32'd0);
        chk("mid_rst_err_count", 32'(bus.err_count), 32'd0);
        chk("mid_rst_suspend",   32'(bus.suspend),   32'd0);
        exp_q.delete();
        m_pkts = 16'd0;
        m_errs = 16'd0;
        reset     = 1'b0;
        rd_enable = 1'b1;
        send_pkt(8'h0C, 8'h33, 8'h05, 1'b0, -1);
        drain("drain_after_reset");
        chk("final_overflow", 32'(bus.overflow), 32'd0);

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
